// File: rtl/mem_access_controller.sv
// mem_access_controller: sequences RV32I loads/stores (byte/half/word) onto a
// byte-wide data memory port, one byte per cycle, little-endian.
// Loads are reassembled and sign/zero extended. Misaligned or illegal requests
// are answered with resp_error and never touch memory.
// Optional build macro: MEM_ACCESS_STATS_EN adds load/store/error counters.
module mem_access_controller #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_error,
   output logic            mem_read_enable,
   output logic            mem_write_enable,
   output logic [XLEN-1:0] mem_addr,
   output logic [7:0]      mem_wdata,
   input  logic [7:0]      mem_rdata
`ifdef MEM_ACCESS_STATS_EN
   ,
   output logic [31:0]     stat_loads,
   output logic [31:0]     stat_stores,
   output logic [31:0]     stat_errors
`endif
);

   typedef enum logic [2:0] {IDLE, READ, RWAIT, WRITE, RESP} state_t;

   typedef struct packed {
      logic            write;
      logic [2:0]      funct3;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } req_t;

   state_t          state, nxt;
   req_t            rq;
   logic            err;
   logic [2:0]      cnt;
   logic [XLEN-1:0] asm_q;
   logic            in_err;
   logic [2:0]      last;
   logic [1:0]      cap_lane;
   logic            rd_en, wr_en;

   // index of the final byte of a transfer: 0, 1 or 3
   function automatic logic [2:0] last_idx(input logic [1:0] sz);
      case (sz)
         2'b00:   last_idx = 3'd0;
         2'b01:   last_idx = 3'd1;
         default: last_idx = 3'd3;
      endcase
   endfunction

   assign last     = last_idx(rq.funct3[1:0]);
   // read data for the byte issued last cycle lands in lane cnt-1
   assign cap_lane = 2'(cnt - 3'd1);

   // classify the incoming request: illegal funct3 or misaligned address
   always_comb begin
      in_err = 1'b0;
      case (req_funct3)
         3'b011, 3'b110, 3'b111: in_err = 1'b1;
         default: ;
      endcase
      if (req_write && req_funct3[2])                        in_err = 1'b1;
      if (req_funct3[1:0] == 2'b01 && req_addr[0])           in_err = 1'b1;
      if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b0) in_err = 1'b1;
   end

   // next-state and handshake/strobe decode
   always_comb begin
      nxt        = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) nxt = in_err ? RESP : (req_write ? WRITE : READ);
         end
         READ: begin
            rd_en = 1'b1;
            if (cnt == last) nxt = RWAIT;
         end
         RWAIT: nxt = RESP;
         WRITE: begin
            wr_en = 1'b1;
            if (cnt == last) nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            nxt        = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // a transfer in flight at a reset edge must not commit, so strobes drop with reset_n
   assign mem_read_enable  = rd_en & reset_n;
   assign mem_write_enable = wr_en & reset_n;
   assign mem_addr  = (mem_read_enable | mem_write_enable) ? rq.addr + XLEN'(cnt) : '0;
   assign mem_wdata = mem_write_enable ? rq.wdata[8*cnt[1:0] +: 8] : 8'h00;
   assign resp_error = resp_valid & err;

   // extend the assembled load; stores and errors return zero
   always_comb begin
      resp_rdata = '0;
      if (resp_valid && !err && !rq.write) begin
         case (rq.funct3)
            3'b000:  resp_rdata = {{(XLEN-8){asm_q[7]}}, asm_q[7:0]};
            3'b001:  resp_rdata = {{(XLEN-16){asm_q[15]}}, asm_q[15:0]};
            3'b100:  resp_rdata = {{(XLEN-8){1'b0}}, asm_q[7:0]};
            3'b101:  resp_rdata = {{(XLEN-16){1'b0}}, asm_q[15:0]};
            default: resp_rdata = asm_q;
         endcase
      end
   end

   // state, byte counter, request latch and read assembly
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= 3'd0;
         asm_q <= '0;
         rq    <= '0;
         err   <= 1'b0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: begin
               cnt <= 3'd0;
               if (req_valid) begin
                  rq    <= '{write: req_write, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
                  err   <= in_err;
                  asm_q <= '0;
               end
            end
            READ: begin
               cnt <= cnt + 3'd1;
               if (cnt != 3'd0) asm_q[8*cap_lane +: 8] <= mem_rdata;
            end
            RWAIT: asm_q[8*cap_lane +: 8] <= mem_rdata;
            WRITE: cnt <= cnt + 3'd1;
            default: ;
         endcase
      end
   end

`ifdef MEM_ACCESS_STATS_EN
   // per-class completion counters, bumped in the response cycle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stat_loads  <= 32'd0;
         stat_stores <= 32'd0;
         stat_errors <= 32'd0;
      end else if (state == RESP) begin
         if (err)           stat_errors <= stat_errors + 32'd1;
         else if (rq.write) stat_stores <= stat_stores + 32'd1;
         else               stat_loads  <= stat_loads + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_controller.sv
// Testbench for mem_access_controller: byte-wide memory model, reference byte
// image and a scoreboard queue of expected responses.
`timescale 1ns/1ps
module tb_mem_access_controller;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_error;
   logic [31:0] resp_rdata;
   logic        mem_read_enable, mem_write_enable;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
`ifdef MEM_ACCESS_STATS_EN
   logic [31:0] stat_loads, stat_stores, stat_errors;
`endif

   mem_access_controller #(.XLEN(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
      .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ACCESS_STATS_EN
      , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errors(stat_errors)
`endif
   );

   // byte memory: read data one cycle after the strobe
   logic [7:0] mem [0:1023];
   logic       loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
         mem[10'h100] <= 8'h11; mem[10'h101] <= 8'h22;
         mem[10'h102] <= 8'h83; mem[10'h103] <= 8'h44;
         mem[10'h300] <= 8'h55; mem[10'h301] <= 8'h66;
         mem[10'h302] <= 8'h77; mem[10'h303] <= 8'h88;
         loaded <= 1'b1;
      end else if (mem_write_enable) begin
         mem[mem_addr[9:0]] <= mem_wdata;
      end
      if (mem_read_enable) mem_rdata <= mem[mem_addr[9:0]];
   end

   logic [7:0] ref_mem [0:1023];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          n;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] tr_addr[$];
   logic [7:0]  tr_data[$];
   int          tr_rd, tr_wr;
   logic        tr_both;

   function automatic exp_t model(input logic w, input logic [2:0] f3,
                                  input logic [31:0] a);
      exp_t e;
      logic [31:0] v, ai;
      int n;
      n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      e.err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (w && f3[2]) ||
              (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
      e.rdata = 32'h0;
      e.n = e.err ? 0 : n;
      if (e.err)  e.lat = 1;
      else if (w) e.lat = n + 1;
      else begin
         e.lat = n + 2;
         v = 32'h0;
         for (int i = 0; i < n; i++) begin
            ai = a + i;
            v[8*i +: 8] = ref_mem[ai[9:0]];
         end
         case (f3)
            3'b000:  v = {{24{v[7]}}, v[7:0]};
            3'b001:  v = {{16{v[15]}}, v[15:0]};
            default: ;
         endcase
         e.rdata = v;
      end
      return e;
   endfunction

   // drive one request once the controller is idle and log its expectation
   task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
      exp_t e;
      logic [31:0] ai;
      int k;
      k = 0;
      while (req_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
      e = model(w, f3, a);
      sb.push_back(e);
      if (w && !e.err)
         for (int i = 0; i < e.n; i++) begin
            ai = a + i;
            ref_mem[ai[9:0]] = wd[8*i +: 8];
         end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // observe memory strobes until the response (cycle 1 = first cycle after acceptance)
   task automatic collect(output int lat, output logic [31:0] rd, output logic er);
      lat = -1; rd = 32'hx; er = 1'bx;
      tr_addr.delete(); tr_data.delete(); tr_rd = 0; tr_wr = 0; tr_both = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (mem_read_enable) begin tr_rd++; tr_addr.push_back(mem_addr); end
         if (mem_write_enable) begin
            tr_wr++; tr_addr.push_back(mem_addr); tr_data.push_back(mem_wdata);
         end
         if (mem_read_enable && mem_write_enable) tr_both = 1'b1;
         if (resp_valid) begin lat = k; rd = resp_rdata; er = resp_error; break; end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      n_checks++;
      if ({req_ready, resp_valid, resp_error, mem_read_enable, mem_write_enable} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got rdy/vld/err/re/we=%b required 10000",
                  {req_ready, resp_valid, resp_error, mem_read_enable, mem_write_enable});
      end
      n_checks++;
      if (resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin
         n_fail++;
         $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h required all zero",
                  resp_rdata, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_loads();
      logic [2:0]  f3s [0:4];
      logic [31:0] adr [0:4];
      int lat; logic [31:0] rd; logic er; exp_t e; logic ok;
      f3s[0] = 3'b010; adr[0] = 32'h100;
      f3s[1] = 3'b000; adr[1] = 32'h102;
      f3s[2] = 3'b100; adr[2] = 32'h102;
      f3s[3] = 3'b001; adr[3] = 32'h102;
      f3s[4] = 3'b101; adr[4] = 32'h100;
      for (int i = 0; i < 5; i++) begin
         send(1'b0, f3s[i], adr[i], 32'h0);
         collect(lat, rd, er);
         if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL load_sb[%0d]: got empty scoreboard required one entry", i);
            continue;
         end
         e = sb.pop_front();
         n_checks++;
         if (rd !== e.rdata || er !== 1'b0) begin
            n_fail++;
            $display("FAIL load_rdata[%0d]: got %h err=%b required %h err=0", i, rd, er, e.rdata);
         end
         n_checks++;
         if (lat != e.lat) begin
            n_fail++;
            $display("FAIL load_latency[%0d]: got %0d required %0d", i, lat, e.lat);
         end
         ok = (tr_rd == e.n) && (tr_wr == 0) && !tr_both;
         for (int j = 0; j < tr_addr.size(); j++) if (tr_addr[j] !== adr[i] + j) ok = 1'b0;
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL load_trace[%0d]: got reads=%0d writes=%0d required reads=%0d at %h.. consecutive",
                     i, tr_rd, tr_wr, e.n, adr[i]);
         end
      end
   endtask

   task automatic test_store();
      int lat; logic [31:0] rd; logic er; exp_t e; logic ok;
      logic [31:0] wd;
      wd = 32'hDEADBEEF;
      send(1'b1, 3'b010, 32'h200, wd);
      collect(lat, rd, er);
      e = sb.pop_front();
      n_checks++;
      if (lat != e.lat || er !== 1'b0 || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL store_resp: got lat=%0d err=%b rdata=%h required lat=%0d err=0 rdata=0",
                  lat, er, rd, e.lat);
      end
      ok = (tr_wr == 4) && (tr_rd == 0) && (tr_data.size() == 4);
      for (int j = 0; j < tr_data.size(); j++)
         if (tr_addr[j] !== 32'h200 + j || tr_data[j] !== wd[8*j +: 8]) ok = 1'b0;
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL store_trace: got writes=%0d reads=%0d required 4 writes EF BE AD DE at 200..203",
                  tr_wr, tr_rd);
      end
      n_checks++;
      if ({mem[10'h203], mem[10'h202], mem[10'h201], mem[10'h200]} !== wd) begin
         n_fail++;
         $display("FAIL store_mem: got %h required %h",
                  {mem[10'h203], mem[10'h202], mem[10'h201], mem[10'h200]}, wd);
      end
      send(1'b0, 3'b010, 32'h200, 32'h0);
      collect(lat, rd, er);
      e = sb.pop_front();
      n_checks++;
      if (rd !== e.rdata || lat != e.lat) begin
         n_fail++;
         $display("FAIL store_readback: got %h lat=%0d required %h lat=%0d", rd, lat, e.rdata, e.lat);
      end
   endtask

   task automatic test_errors();
      logic        ws  [0:3];
      logic [2:0]  f3s [0:3];
      logic [31:0] adr [0:3];
      int lat; logic [31:0] rd; logic er; exp_t e;
      ws[0] = 1'b0; f3s[0] = 3'b010; adr[0] = 32'h102;
      ws[1] = 1'b1; f3s[1] = 3'b001; adr[1] = 32'h101;
      ws[2] = 1'b0; f3s[2] = 3'b011; adr[2] = 32'h100;
      ws[3] = 1'b1; f3s[3] = 3'b100; adr[3] = 32'h100;
      for (int i = 0; i < 4; i++) begin
         send(ws[i], f3s[i], adr[i], 32'hFFFF_FFFF);
         collect(lat, rd, er);
         e = sb.pop_front();
         n_checks++;
         if (er !== e.err || rd !== 32'h0 || lat != e.lat) begin
            n_fail++;
            $display("FAIL error_resp[%0d]: got err=%b rdata=%h lat=%0d required err=%b rdata=0 lat=%0d",
                     i, er, rd, lat, e.err, e.lat);
         end
         n_checks++;
         if (tr_rd + tr_wr != 0) begin
            n_fail++;
            $display("FAIL error_nomem[%0d]: got %0d strobes required 0", i, tr_rd + tr_wr);
         end
      end
   endtask

   task automatic test_back_to_back();
      int accepts, resps, last_acc;
      logic gap_bad, busy_bad, r;
      exp_t e;
      accepts = 0; resps = 0; last_acc = -1; gap_bad = 1'b0; busy_bad = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b000; req_addr = 32'h100;
      for (int cyc = 0; cyc < 40; cyc++) begin
         r = req_ready;
         if (resp_valid) begin
            resps++;
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_sb: got response with empty scoreboard required none");
            end else begin
               e = sb.pop_front();
               if (resp_rdata !== e.rdata) begin
                  n_fail++;
                  $display("FAIL b2b_rdata: got %h required %h", resp_rdata, e.rdata);
               end
            end
         end
         @(posedge clk);
         if (r === 1'b1) begin
            accepts++;
            sb.push_back(model(1'b0, 3'b000, 32'h100));
            if (last_acc >= 0 && cyc - last_acc != 4) gap_bad = 1'b1;
            last_acc = cyc;
         end
         @(negedge clk);
         if (r === 1'b1 && req_ready !== 1'b0) busy_bad = 1'b1;
      end
      req_valid = 1'b0;
      n_checks++;
      if (accepts != 10 || resps != 10 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_count: got accepts=%0d resps=%0d pending=%0d required 10/10/0",
                  accepts, resps, sb.size());
      end
      n_checks++;
      if (gap_bad || busy_bad) begin
         n_fail++;
         $display("FAIL b2b_ready: got gap_bad=%b busy_bad=%b required 0/0", gap_bad, busy_bad);
      end
      sb.delete();
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int k; logic saw_resp;
      k = 0;
      while (req_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h300; req_wdata = 32'hA1B2C3D4;
      @(posedge clk);
      @(negedge clk);                 // byte 0
      req_valid = 1'b0;
      @(negedge clk);                 // byte 1
      @(negedge clk);                 // byte 2
      n_checks++;
      if (mem_write_enable !== 1'b1 || mem_addr !== 32'h302) begin
         n_fail++;
         $display("FAIL midrst_third: got we=%b addr=%h required we=1 addr=00000302",
                  mem_write_enable, mem_addr);
      end
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_write_enable !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_idle: got rdy=%b vld=%b we=%b required 1/0/0",
                  req_ready, resp_valid, mem_write_enable);
      end
      saw_resp = 1'b0;
      repeat (8) begin @(negedge clk); if (resp_valid) saw_resp = 1'b1; end
      n_checks++;
      if (saw_resp) begin
         n_fail++;
         $display("FAIL midrst_noresp: got resp_valid=1 required 0");
      end
      n_checks++;
      if ({mem[10'h303], mem[10'h302], mem[10'h301], mem[10'h300]} !== 32'h8877C3D4) begin
         n_fail++;
         $display("FAIL midrst_mem: got %h required 8877c3d4",
                  {mem[10'h303], mem[10'h302], mem[10'h301], mem[10'h300]});
      end
   endtask

`ifdef MEM_ACCESS_STATS_EN
   task automatic test_stats();
      int lat; logic [31:0] rd; logic er; exp_t e;
      send(1'b0, 3'b010, 32'h100, 32'h0);   collect(lat, rd, er); e = sb.pop_front();
      send(1'b1, 3'b010, 32'h204, 32'h1234); collect(lat, rd, er); e = sb.pop_front();
      send(1'b0, 3'b001, 32'h101, 32'h0);   collect(lat, rd, er); e = sb.pop_front();
      n_checks++;
      if (stat_loads !== 32'd1 || stat_stores !== 32'd1 || stat_errors !== 32'd1) begin
         n_fail++;
         $display("FAIL stats: got l/s/e=%0d/%0d/%0d required 1/1/1",
                  stat_loads, stat_stores, stat_errors);
      end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish required finish within 500us");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
      ref_mem[10'h100] = 8'h11; ref_mem[10'h101] = 8'h22;
      ref_mem[10'h102] = 8'h83; ref_mem[10'h103] = 8'h44;
      test_reset();
      test_loads();
      test_store();
      test_errors();
      test_back_to_back();
      test_reset_mid();
`ifdef MEM_ACCESS_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
